ball_pocket_tracker: RTL and testbench

//  Decides, frame by frame, when a ball has fallen into a hole, and keeps the set of balls still on the table.

---
 rtl/ball_pocket_tracker.sv | 140 ++++++++++++++
 tb/tb_ball_pocket_tracker.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ball_pocket_tracker.sv
// Per-ball pocket detector: counts ball/hole pixel overlap each frame and confirms a pocket
// only after CONFIRM_FRAMES consecutive qualifying frames, then reports it to the game controller.
module ball_pocket_tracker #(
  parameter int NUM_BALLS      = 2,
  parameter int OVERLAP_MIN    = 16,
  parameter int CONFIRM_FRAMES = 3
) (
  input  logic                 clk,
  input  logic                 resetN,
  input  logic                 startOfFrame,
  input  logic [NUM_BALLS:0]   ball_draw_req,
  input  logic                 hole_draw_req,
  input  logic [2:0]           hole_id,
  input  logic                 restore_balls,
  output logic [NUM_BALLS:0]   balls_in_game,
  output logic [NUM_BALLS:0]   ballhole_collide,
  output logic [2:0]           curr_Hole_id
);

  localparam int             NB            = NUM_BALLS + 1;
  localparam logic [7:0]     OVERLAP_MIN_W = 8'(OVERLAP_MIN);
  localparam logic [3:0]     CONFIRM_W     = 4'(CONFIRM_FRAMES);

  typedef enum logic [1:0] {IN_PLAY, SINKING, POCKETED} state_t;

  logic [NB-1:0]       pocket_now;
  logic [NB-1:0][2:0]  cand_hole;

  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_ball
      state_t     state_q, state_d;
      logic [7:0] pix_cnt_q, pix_cnt_d;
      logic [3:0] frame_cnt_q, frame_cnt_d;
      logic [2:0] cand_q, cand_d;
      logic       pocket_d;
      logic       qualify;

      assign qualify        = (pix_cnt_q >= OVERLAP_MIN_W);
      assign pocket_now[gi] = pocket_d;
      assign cand_hole[gi]  = cand_q;

      always_comb begin
        state_d     = state_q;
        pix_cnt_d   = pix_cnt_q;
        frame_cnt_d = frame_cnt_q;
        cand_d      = cand_q;
        pocket_d    = 1'b0;
        if (restore_balls) begin
          // Restore wins over a coincident frame boundary: that frame's result is dropped.
          state_d     = IN_PLAY;
          pix_cnt_d   = 8'd0;
          frame_cnt_d = 4'd0;
        end else if (startOfFrame) begin
          pix_cnt_d = 8'd0;
          case (state_q)
            IN_PLAY: begin
              if (qualify) begin
                if (CONFIRM_W == 4'd1) begin
                  state_d  = POCKETED;
                  pocket_d = 1'b1;
                end else begin
                  state_d     = SINKING;
                  frame_cnt_d = 4'd1;
                end
              end
            end
            SINKING: begin
              if (!qualify) begin
                state_d     = IN_PLAY;
                frame_cnt_d = 4'd0;
              end else if (frame_cnt_q + 4'd1 == CONFIRM_W) begin
                state_d     = POCKETED;
                frame_cnt_d = 4'd0;
                pocket_d    = 1'b1;
              end else begin
                frame_cnt_d = frame_cnt_q + 4'd1;
              end
            end
            default: ;
          endcase
        end else if (ball_draw_req[gi] && hole_draw_req && state_q != POCKETED) begin
          if (pix_cnt_q == 8'd0) cand_d = hole_id;
          if (pix_cnt_q != 8'hFF) pix_cnt_d = pix_cnt_q + 8'd1;
        end
      end

      always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
          state_q     <= IN_PLAY;
          pix_cnt_q   <= 8'd0;
          frame_cnt_q <= 4'd0;
          cand_q      <= 3'd0;
        end else begin
          state_q     <= state_d;
          pix_cnt_q   <= pix_cnt_d;
          frame_cnt_q <= frame_cnt_d;
          cand_q      <= cand_d;
        end
      end
    end
  endgenerate

  logic [NB-1:0] balls_in_game_q, balls_in_game_d;
  logic [NB-1:0] collide_q, collide_d;
  logic [2:0]    hole_q, hole_d;

  always_comb begin
    balls_in_game_d = balls_in_game_q;
    collide_d       = '0;
    hole_d          = hole_q;
    if (restore_balls) begin
      balls_in_game_d = '1;
    end else begin
      balls_in_game_d = balls_in_game_q & ~pocket_now;
      collide_d       = pocket_now;
      // Descending scan so the lowest-index ball pocketed this frame names the hole.
      for (int i = NB - 1; i >= 0; i--) begin
        if (pocket_now[i]) hole_d = cand_hole[i];
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      balls_in_game_q <= '1;
      collide_q       <= '0;
      hole_q          <= 3'd0;
    end else begin
      balls_in_game_q <= balls_in_game_d;
      collide_q       <= collide_d;
      hole_q          <= hole_d;
    end
  end

  assign balls_in_game    = balls_in_game_q;
  assign ballhole_collide = collide_q;
  assign curr_Hole_id     = hole_q;

endmodule

// File: tb/tb_ball_pocket_tracker.sv
// Bench for ball_pocket_tracker: directed scenarios plus random frames, checked every cycle
// against a frame-level model (overlap totals and qualifying-frame streaks per ball).
module tb_ball_pocket_tracker;

  logic       clk;
  logic       resetN;
  logic       startOfFrame;
  logic [2:0] ball_draw_req;
  logic       hole_draw_req;
  logic [2:0] hole_id;
  logic       restore_balls;
  logic [2:0] balls_in_game;
  logic [2:0] ballhole_collide;
  logic [2:0] curr_Hole_id;

  int checks = 0;
  int errors = 0;

  ball_pocket_tracker #(.NUM_BALLS(2), .OVERLAP_MIN(16), .CONFIRM_FRAMES(3)) dut (
    .clk              (clk),
    .resetN           (resetN),
    .startOfFrame     (startOfFrame),
    .ball_draw_req    (ball_draw_req),
    .hole_draw_req    (hole_draw_req),
    .hole_id          (hole_id),
    .restore_balls    (restore_balls),
    .balls_in_game    (balls_in_game),
    .ballhole_collide (ballhole_collide),
    .curr_Hole_id     (curr_Hole_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Frame-level model: overlap total this frame, first hole touched, run of qualifying frames.
  int         ovl [3];
  int         first_hole [3];
  int         streak [3];
  bit         pocketed [3];
  logic [2:0] exp_big, exp_col, exp_hole;

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      ovl[i] = 0; first_hole[i] = 0; streak[i] = 0; pocketed[i] = 0;
    end
    exp_big = 3'b111; exp_col = 3'b000; exp_hole = 3'd0;
  endtask

  task automatic model_step();
    exp_col = 3'b000;
    if (restore_balls) begin
      for (int i = 0; i < 3; i++) begin
        ovl[i] = 0; streak[i] = 0; pocketed[i] = 0;
      end
      exp_big = 3'b111;
    end else if (startOfFrame) begin
      for (int i = 0; i < 3; i++) begin
        if (!pocketed[i]) begin
          streak[i] = (ovl[i] >= 16) ? streak[i] + 1 : 0;
          if (streak[i] >= 3) begin
            pocketed[i] = 1;
            exp_col[i]  = 1'b1;
          end
        end
        ovl[i] = 0;
      end
      exp_big = exp_big & ~exp_col;
      for (int i = 2; i >= 0; i--)
        if (exp_col[i]) exp_hole = 3'(first_hole[i]);
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (ball_draw_req[i] && hole_draw_req && !pocketed[i]) begin
          if (ovl[i] == 0) first_hole[i] = int'(hole_id);
          ovl[i]++;
        end
      end
    end
  endtask

  // Single compare process: every cycle, 1 time unit after the active edge.
  always @(posedge clk) begin
    if (!resetN) model_reset();
    else model_step();
    #1;
    checks++;
    if (balls_in_game !== exp_big || ballhole_collide !== exp_col || curr_Hole_id !== exp_hole) begin
      errors++;
      $display("FAIL cycle_compare t=%0t: got big=%b col=%b hole=%0d, expected big=%b col=%b hole=%0d",
               $time, balls_in_game, ballhole_collide, curr_Hole_id, exp_big, exp_col, exp_hole);
    end
  end

  task automatic step(input logic [2:0] b, input logic h, input logic [2:0] id,
                      input logic s, input logic r);
    @(negedge clk);
    ball_draw_req = b; hole_draw_req = h; hole_id = id; startOfFrame = s; restore_balls = r;
  endtask

  task automatic idle();
    step(3'b000, 1'b0, 3'd0, 1'b0, 1'b0);
  endtask

  task automatic pixels(input logic [2:0] b, input logic [2:0] id, input int n);
    for (int k = 0; k < n; k++) step(b, 1'b1, id, 1'b0, 1'b0);
    idle();
  endtask

  // Leaves the bench at the negedge right after the SOF edge, so any pulse is visible.
  task automatic end_frame();
    step(3'b000, 1'b0, 3'd0, 1'b1, 1'b0);
    idle();
  endtask

  task automatic frame(input logic [2:0] b, input logic [2:0] id, input int n);
    pixels(b, id, n);
    end_frame();
  endtask

  task automatic restore();
    step(3'b000, 1'b0, 3'd0, 1'b0, 1'b1);
    idle();
  endtask

  task automatic expect_out(input string name, input logic [2:0] big,
                            input logic [2:0] col, input logic [2:0] hole);
    checks++;
    if (balls_in_game !== big || ballhole_collide !== col || curr_Hole_id !== hole) begin
      errors++;
      $display("FAIL %s: got big=%b col=%b hole=%0d, expected big=%b col=%b hole=%0d",
               name, balls_in_game, ballhole_collide, curr_Hole_id, big, col, hole);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    resetN = 1'b0;
    ball_draw_req = 3'b000; hole_draw_req = 1'b0; hole_id = 3'd0;
    startOfFrame = 1'b0; restore_balls = 1'b0;
    repeat (3) @(negedge clk);
    expect_out("reset_state", 3'b111, 3'b000, 3'd0);
    resetN = 1'b1;
    idle();
    $display("test reset done");

    // Ball 1 on hole 4, three qualifying frames.
    frame(3'b010, 3'd4, 20);
    frame(3'b010, 3'd4, 20);
    expect_out("ball1_no_pulse_yet", 3'b111, 3'b000, 3'd0);
    frame(3'b010, 3'd4, 20);
    expect_out("ball1_pocket", 3'b101, 3'b010, 3'd4);
    idle();
    expect_out("ball1_pulse_one_cycle", 3'b101, 3'b000, 3'd4);
    $display("test single pocket done");

    // Ball 2: a short frame breaks the streak.
    restore();
    expect_out("restore_after_ball1", 3'b111, 3'b000, 3'd4);
    frame(3'b100, 3'd1, 20);
    frame(3'b100, 3'd1, 20);
    frame(3'b100, 3'd1, 10);
    frame(3'b100, 3'd1, 20);
    expect_out("ball2_debounced", 3'b111, 3'b000, 3'd4);
    $display("test debounce done");

    // Balls 1 and 2 pocketed at the same boundary.
    restore();
    for (int f = 0; f < 3; f++) begin
      pixels(3'b010, 3'd2, 20);
      pixels(3'b100, 3'd5, 20);
      end_frame();
    end
    expect_out("simultaneous_pocket", 3'b001, 3'b110, 3'd2);
    $display("test simultaneous done");

    // White ball pocketed, then further overlap is ignored.
    restore();
    for (int f = 0; f < 3; f++) frame(3'b001, 3'd1, 20);
    expect_out("white_pocket", 3'b110, 3'b001, 3'd1);
    for (int f = 0; f < 5; f++) begin
      frame(3'b001, 3'd3, 20);
      expect_out("white_no_repulse", 3'b110, 3'b000, 3'd1);
    end
    $display("test white ball done");

    // Restore coincident with SOF, then pocket again.
    restore();
    for (int f = 0; f < 3; f++) frame(3'b010, 3'd3, 20);
    expect_out("ball1_pocket_hole3", 3'b101, 3'b010, 3'd3);
    pixels(3'b100, 3'd5, 20);
    step(3'b000, 1'b0, 3'd0, 1'b1, 1'b1);
    idle();
    expect_out("restore_beats_sof", 3'b111, 3'b000, 3'd3);
    for (int f = 0; f < 3; f++) frame(3'b010, 3'd0, 20);
    expect_out("ball1_repocket", 3'b101, 3'b010, 3'd0);
    $display("test restore with sof done");

    // Mid-frame reset discards the partial count.
    restore();
    pixels(3'b010, 3'd1, 10);
    @(negedge clk) resetN = 1'b0;
    idle();
    @(negedge clk) resetN = 1'b1;
    pixels(3'b010, 3'd1, 10);
    end_frame();
    frame(3'b010, 3'd1, 20);
    frame(3'b010, 3'd1, 20);
    expect_out("reset_discards_partial", 3'b111, 3'b000, 3'd0);
    $display("test mid-frame reset done");

    // Overlap beyond 255 pixels must saturate, not wrap.
    restore();
    for (int f = 0; f < 3; f++) frame(3'b001, 3'd2, 260);
    expect_out("saturation_pocket", 3'b110, 3'b001, 3'd2);
    $display("test saturation done");

    // Random frames, checked only by the per-cycle model.
    restore();
    for (int f = 0; f < 200; f++) begin
      int segs;
      int sel;
      segs = $urandom_range(1, 4);
      for (int s = 0; s < segs; s++) begin
        logic [2:0] b;
        logic       h;
        logic [2:0] id;
        int         n;
        b  = 3'($urandom);
        h  = ($urandom_range(0, 3) != 0);
        id = 3'($urandom_range(0, 5));
        n  = $urandom_range(0, 12);
        for (int k = 0; k < n; k++) step(b, h, id, 1'b0, 1'b0);
      end
      sel = $urandom_range(0, 9);
      if (sel == 0) begin
        step(3'b000, 1'b0, 3'd0, 1'b0, 1'b1);
        step(3'b000, 1'b0, 3'd0, 1'b1, 1'b0);
      end else if (sel == 1) begin
        step(3'b000, 1'b0, 3'd0, 1'b1, 1'b1);
      end else begin
        step(3'b000, 1'b0, 3'd0, 1'b1, 1'b0);
      end
      idle();
    end
    idle();
    idle();
    $display("test random frames done");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
